// File: rtl/ram8_req_ctrl.sv
// Request sequencer in front of RAM8: write = 1 cycle, read response valid 2 cycles after accept, clear = 2**ADDR_W cycles.
// Backpressure: req_ready drops whenever busy or clr_start is high; a held response stalls the sequencer until rsp_ready.
module ram8_req_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clr_start,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_sel,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_lat_addr;
    logic [DATA_W-1:0]   r_lat_data;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic [CNT_W-1:0]    r_wr_count;
    logic [CNT_W-1:0]    r_rd_count;
    logic                w_req_acc;
    logic                w_rsp_hs;

    assign req_ready = (r_state == S_IDLE) & ~clr_start;
    assign busy      = (r_state != S_IDLE);
    assign w_req_acc = req_valid & req_ready;
    assign w_rsp_hs  = r_rsp_valid & rsp_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (clr_start)
                    w_state_nxt = S_CLEAR;
                else if (w_req_acc)
                    w_state_nxt = req_we ? S_WRITE : S_READ;
            end
            S_WRITE: w_state_nxt = S_IDLE;
            S_READ:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            S_CLEAR: if (&r_clr_cnt) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM drive is decoded from registered state only, so reset silences it immediately.
    always_comb begin
        ram_load = 1'b0;
        ram_sel  = '0;
        ram_in   = '0;
        unique case (r_state)
            S_WRITE: begin
                ram_load = 1'b1;
                ram_sel  = r_lat_addr;
                ram_in   = r_lat_data;
            end
            S_READ:  ram_sel = r_lat_addr;
            S_CLEAR: begin
                ram_load = 1'b1;
                ram_sel  = r_clr_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat_addr  <= '0;
            r_lat_data  <= '0;
            r_clr_cnt   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_clr_cnt <= '0;
                    end else if (w_req_acc) begin
                        r_lat_addr <= req_addr;
                        r_lat_data <= req_wdata;
                    end
                end
                S_WRITE: begin
                    if (!(&r_wr_count))
                        r_wr_count <= r_wr_count + CNT_W'(1);
                end
                S_READ: begin
                    r_rsp_data  <= ram_out;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        if (!(&r_rd_count))
                            r_rd_count <= r_rd_count + CNT_W'(1);
                    end
                end
                S_CLEAR: r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_req_ctrl.sv
// Bench for ram8_req_ctrl: cycle table, reset/saturation sequences, then randomized traffic against a transaction-level model.
module tb_ram8_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        clr_start, busy, rsp_valid, rsp_ready;
    logic [15:0] rsp_data, ram_in, ram_out;
    logic [2:0]  ram_sel;
    logic        ram_load;
    logic [7:0]  wr_count, rd_count;

    int n_checks = 0;
    int n_errors = 0;

    ram8_req_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .clr_start(clr_start), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_in(ram_in), .ram_sel(ram_sel), .ram_load(ram_load), .ram_out(ram_out),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    // Simple RAM8 stand-in: synchronous write, combinational read.
    logic [15:0] ram_mem [8];
    always @(posedge clk) if (ram_load) ram_mem[ram_sel] <= ram_in;
    assign ram_out = ram_mem[ram_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        vld, we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        clr, rrdy;
        logic        e_rdy, e_busy, e_load;
        logic [2:0]  e_sel;
        logic [15:0] e_in;
        logic        e_rv;
        logic [15:0] e_rd;
        logic [7:0]  e_wr, e_rc;
    } vec_t;

    function automatic vec_t mk(input logic vld, we, input logic [2:0] addr, input logic [15:0] wdata,
                                input logic clr, rrdy, e_rdy, e_busy, e_load, input logic [2:0] e_sel,
                                input logic [15:0] e_in, input logic e_rv, input logic [15:0] e_rd,
                                input logic [7:0] e_wr, e_rc);
        vec_t v;
        v.vld = vld; v.we = we; v.addr = addr; v.wdata = wdata; v.clr = clr; v.rrdy = rrdy;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_load = e_load; v.e_sel = e_sel; v.e_in = e_in;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_wr = e_wr; v.e_rc = e_rc;
        return v;
    endfunction

    // Transaction-level model state for the random phase.
    logic [15:0] m_mem [8];
    logic [15:0] exp_q [$];
    int          m_wr, m_rd;
    logic        prev_stall;
    logic [15:0] prev_data;

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        int waited = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk("wr_accept_timeout", waited, 0);
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic rand_cycle(input logic drain);
        logic [15:0] e;
        req_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 3'($urandom_range(0, 7));
        req_wdata = 16'($urandom);
        clr_start = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
        rsp_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (prev_stall) begin
            chk("rnd_rsp_hold_valid", rsp_valid, 1);
            chk("rnd_rsp_hold_data", rsp_data, prev_data);
        end
        chk("rnd_req_ready", req_ready, !busy && !clr_start);
        if (clr_start && !busy) begin
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
        end else if (req_valid && req_ready) begin
            if (req_we) begin
                m_mem[req_addr] = req_wdata;
                if (m_wr < 255) m_wr++;
            end else begin
                exp_q.push_back(m_mem[req_addr]);
            end
        end
        if (rsp_valid && rsp_ready) begin
            chk("rnd_rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rnd_rsp_data", rsp_data, e);
            end
            if (m_rd < 255) m_rd++;
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        tick();
    endtask

    initial begin
        vec_t tbl [$];
        int   waited;

        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        clr_start = 0; rsp_ready = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_load", ram_load, 0);
        chk("rst_sel", ram_sel, 0);
        chk("rst_in", ram_in, 0);
        chk("rst_wr", wr_count, 0);
        chk("rst_rd", rd_count, 0);
        chk("rst_ready", req_ready, 1);
        @(negedge clk); rst = 1'b0;
        tick();

        //              vld we ad wdata   clr rr | rdy bsy ld sel in      rv rd      wr rc
        tbl.push_back(mk(1, 1, 5, 16'hBEEF, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 1, 5, 16'hBEEF, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 5, 16'h0000, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 0, 5, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 0, 0, 16'h0000, 1, 16'hBEEF, 1, 0));
        tbl.push_back(mk(1, 1, 2, 16'h1234, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 1, 2, 16'h1234, 0, 16'hBEEF, 1, 1));
        tbl.push_back(mk(1, 0, 2, 16'h0000, 0, 0,  1, 0, 0, 0, 16'h0000, 0, 16'hBEEF, 2, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0,  0, 1, 0, 2, 16'h0000, 0, 16'hBEEF, 2, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0000, 1, 16'h1234, 2, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 0, 0, 16'h0000, 1, 16'h1234, 2, 1));
        tbl.push_back(mk(1, 1, 7, 16'h5555, 1, 1,  0, 0, 0, 0, 16'h0000, 0, 16'h1234, 2, 2));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 7, 16'h5555, 0, 1,  0, 1, 1, 3'(i), 16'h0000, 0, 16'h1234, 2, 2));
        tbl.push_back(mk(1, 1, 7, 16'h5555, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 16'h1234, 2, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  0, 1, 1, 7, 16'h5555, 0, 16'h1234, 2, 2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 16'h1234, 3, 2));

        foreach (tbl[i]) begin
            req_valid = tbl[i].vld; req_we = tbl[i].we; req_addr = tbl[i].addr;
            req_wdata = tbl[i].wdata; clr_start = tbl[i].clr; rsp_ready = tbl[i].rrdy;
            @(negedge clk);
            chk($sformatf("t%0d_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("t%0d_load", i), ram_load, tbl[i].e_load);
            chk($sformatf("t%0d_sel", i), ram_sel, tbl[i].e_sel);
            chk($sformatf("t%0d_in", i), ram_in, tbl[i].e_in);
            chk($sformatf("t%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
            chk($sformatf("t%0d_rsp_data", i), rsp_data, tbl[i].e_rd);
            chk($sformatf("t%0d_wr_count", i), wr_count, tbl[i].e_wr);
            chk($sformatf("t%0d_rd_count", i), rd_count, tbl[i].e_rc);
            tick();
        end
        req_valid = 0; clr_start = 0;

        // Reset in the third cycle of a clear.
        clr_start = 1; tick(); clr_start = 0;
        tick(); tick();
        chk("clr3_load_before", ram_load, 1);
        chk("clr3_sel_before", ram_sel, 2);
        #2 rst = 1'b1; #1;
        chk("clr_rst_load", ram_load, 0);
        chk("clr_rst_busy", busy, 0);
        chk("clr_rst_sel", ram_sel, 0);
        chk("clr_rst_wr", wr_count, 0);
        chk("clr_rst_rd", rd_count, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_clr_rst_load", ram_load, 0);
            chk("post_clr_rst_busy", busy, 0);
        end

        // Reset while a response is pending.
        rsp_ready = 0; req_valid = 1; req_we = 0; req_addr = 5;
        tick(); req_valid = 0;
        tick();
        chk("resp_pending_valid", rsp_valid, 1);
        #2 rst = 1'b1; #1;
        chk("resp_rst_valid", rsp_valid, 0);
        chk("resp_rst_busy", busy, 0);
        chk("resp_rst_rd", rd_count, 0);
        @(negedge clk); rst = 1'b0; rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_resp_rst_valid", rsp_valid, 0);
        end

        // Write counter saturation.
        for (int k = 1; k <= 260; k++) begin
            do_write(3'(k), 16'(k));
            if (k >= 254) chk($sformatf("wr_sat_%0d", k), wr_count, (k > 255) ? 255 : k);
        end

        // Randomized traffic from a known-zero memory and zero counters.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tick();
        clr_start = 1; tick(); clr_start = 0;
        waited = 0;
        while (busy && waited < 20) begin tick(); waited++; end
        chk("rnd_clear_done", busy, 0);
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_wr = 0; m_rd = 0; prev_stall = 0; prev_data = '0;
        for (int n = 0; n < 2000; n++) rand_cycle(1'b0);
        for (int n = 0; n < 20; n++) rand_cycle(1'b1);
        @(negedge clk);
        chk("rnd_wr_count", wr_count, m_wr);
        chk("rnd_rd_count", rd_count, m_rd);
        chk("rnd_rsp_outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
